// File: rtl/twist.sv
// Twisted-ring (Johnson) counter, WIDTH bits, period 2*WIDTH; output is the state register itself.
// One step per clk edge with no stall; any state outside the ring is forced back to zero on the next edge.
module twist #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-2:0] pair_diff;
    logic             state_legal;

    // Ring states have at most one boundary between their run of ones and run of zeros.
    assign pair_diff   = cnt_q[WIDTH-2:0] ^ cnt_q[WIDTH-1:1];
    assign state_legal = ((pair_diff & (pair_diff - (WIDTH-1)'(1))) == '0);

    always_comb begin
        cnt_d = '0;
        if (state_legal) begin
            cnt_d = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: tb/tb_twist.sv
// Directed bench for twist at WIDTH=8 and WIDTH=4: table of per-edge vectors plus forced-state sequences.
module tb_twist;

    logic       clk;
    logic       rst8;
    logic       rst4;
    logic [7:0] cnt8;
    logic [3:0] cnt4;

    int pass_cnt;
    int total_cnt;

    twist #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .cnt(cnt8));
    twist #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .cnt(cnt4));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] exp8;
        logic [3:0] exp4;
        logic       one_bit;
    } vec_t;

    vec_t vecs[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int popcnt8(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (v[i] === 1'b1) ? 1 : 0;
        return n;
    endfunction

    // Drive rst, take one edge, sample 5 ns later.
    task automatic step(input logic r);
        rst8 = r;
        rst4 = r;
        @(posedge clk);
        #5;
    endtask

    initial begin
        logic [7:0] seq8 [16];
        logic [3:0] seq4 [8];
        logic [7:0] prev8;
        vec_t       v;

        pass_cnt  = 0;
        total_cnt = 0;
        seq8 = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
        seq4 = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

        // Edges 2..32 after reset release, then six more edges to reach 3F.
        for (int e = 2; e <= 38; e++) begin
            v.rst = 1'b1; v.exp8 = seq8[e % 16]; v.exp4 = seq4[e % 8]; v.one_bit = 1'b1;
            vecs.push_back(v);
        end
        // Mid-sequence reset at 3F (4-bit counter is at C), held two edges, then release.
        v.rst = 1'b0; v.exp8 = 8'h00; v.exp4 = 4'h0; v.one_bit = 1'b0; vecs.push_back(v);
        v.rst = 1'b0; v.exp8 = 8'h00; v.exp4 = 4'h0; v.one_bit = 1'b0; vecs.push_back(v);
        v.rst = 1'b1; v.exp8 = 8'h01; v.exp4 = 4'h1; v.one_bit = 1'b1; vecs.push_back(v);
        v.rst = 1'b1; v.exp8 = 8'h03; v.exp4 = 4'h3; v.one_bit = 1'b1; vecs.push_back(v);

        // Power-up reset: rst low 0-20 ns, edges at 10 and 30 ns.
        rst8 = 1'b0;
        rst4 = 1'b0;
        @(posedge clk);
        #5;
        check8("reset_w8", cnt8, 8'h00);
        check4("reset_w4", cnt4, 4'h0);
        #5;
        rst8 = 1'b1;
        rst4 = 1'b1;
        @(posedge clk);
        #5;
        check8("first_edge_w8", cnt8, 8'h01);
        check4("first_edge_w4", cnt4, 4'h1);

        prev8 = cnt8;
        foreach (vecs[k]) begin
            step(vecs[k].rst);
            check8($sformatf("vec%0d_w8", k), cnt8, vecs[k].exp8);
            check4($sformatf("vec%0d_w4", k), cnt4, vecs[k].exp4);
            if (vecs[k].one_bit) begin
                total_cnt++;
                if (popcnt8(cnt8 ^ prev8) == 1) pass_cnt++;
                else $display("FAIL onebit%0d: changed bits %h from %h to %h", k, cnt8 ^ prev8, prev8, cnt8);
            end
            prev8 = cnt8;
        end

        // Illegal state 0x55 / 0x5 with rst high recovers in one edge.
        force dut8.cnt_q = 8'h55;
        force dut4.cnt_q = 4'h5;
        #1;
        release dut8.cnt_q;
        release dut4.cnt_q;
        check8("forced_55_visible", cnt8, 8'h55);
        step(1'b1);
        check8("recover_55", cnt8, 8'h00);
        check4("recover_5", cnt4, 4'h0);
        step(1'b1);
        check8("resume_after_55", cnt8, 8'h01);
        check4("resume_after_5", cnt4, 4'h1);

        // Illegal state 0x81 / 0x9.
        force dut8.cnt_q = 8'h81;
        force dut4.cnt_q = 4'h9;
        #1;
        release dut8.cnt_q;
        release dut4.cnt_q;
        step(1'b1);
        check8("recover_81", cnt8, 8'h00);
        check4("recover_9", cnt4, 4'h0);
        step(1'b1);
        check8("resume_after_81", cnt8, 8'h01);

        // Walk to a legal non-zero state, then confirm reset wins over an illegal forced value.
        step(1'b1);
        step(1'b1);
        check8("pre_reset_07", cnt8, 8'h07);
        rst8 = 1'b0;
        rst4 = 1'b0;
        force dut8.cnt_q = 8'hA5;
        force dut4.cnt_q = 4'hA;
        #1;
        release dut8.cnt_q;
        release dut4.cnt_q;
        step(1'b0);
        check8("reset_over_A5", cnt8, 8'h00);
        check4("reset_over_A", cnt4, 4'h0);
        step(1'b1);
        check8("release_after_A5", cnt8, 8'h01);
        check4("release_after_A", cnt4, 4'h1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
